// File: rtl/fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: IDLE -> FETCH -> HOLD, stopping in HALTED.
// Latency: at least 2 cycles per instruction. Backpressure: HOLD keeps instr/pc until decode accepts.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_op,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_rs,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] retire_cnt,
  output logic [1:0]  fault,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] OP_PLUS4  = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JUMP   = 2'b10;
  localparam logic [1:0] OP_JR     = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_JR      = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  // State register: all sequential state lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      retire_cnt_q <= 32'd0;
      fault_q      <= FAULT_NONE;
      wait_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
      fault_q      <= fault_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    pc4        = pc_q + 32'd4;
    branch_off = {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
    next_pc    = pc4;
    if (redirect_valid) begin
      case (redirect_op)
        OP_PLUS4:  next_pc = pc4;
        OP_BRANCH: next_pc = pc4 + branch_off;
        OP_JUMP:   next_pc = {pc4[31:28], redirect_imm, 2'b00};
        OP_JR:     next_pc = redirect_rs;
        default:   next_pc = pc4;
      endcase
    end
    jr_misaligned = redirect_valid && (redirect_op == OP_JR) && (redirect_rs[1:0] != 2'b00);
  end

  // Next-state logic; redirect and halt only matter on the accept edge.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    fault_d      = fault_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          wait_cnt_d = 8'd0;
          state_d    = S_HOLD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fault_d = FAULT_TIMEOUT;
          state_d = S_HALTED;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          retire_cnt_d = retire_cnt_q + 32'd1;
          pc_d         = next_pc;
          if (jr_misaligned) begin
            fault_d = FAULT_JR;
            state_d = S_HALTED;
          end else if (halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH:  imem_req    = 1'b1;
      S_HOLD:   instr_valid = 1'b1;
      S_HALTED: halted      = 1'b1;
      default:  ;
    endcase
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign retire_cnt = retire_cnt_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for the main flow plus hand sequences for stalls, timeout and reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_op;
  logic [25:0] redirect_imm;
  logic [31:0] redirect_rs;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] retire_cnt;
  logic [1:0]  fault;
  logic        halted;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_op(redirect_op), .redirect_imm(redirect_imm),
    .redirect_rs(redirect_rs), .halt(halt),
    .pc(pc), .retire_cnt(retire_cnt), .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        rv;
    logic [1:0]  op;
    logic [25:0] imm;
    logic [31:0] rs;
    logic        hlt;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_halted;
    logic [1:0]  e_fault;
    logic [31:0] e_ret;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic ready, logic rv, logic [1:0] op,
                              logic [25:0] imm, logic [31:0] rs, logic hlt, logic e_req, logic [31:0] e_pc,
                              logic e_valid, logic [31:0] e_instr, logic e_halted, logic [1:0] e_fault,
                              logic [31:0] e_ret);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.rv = rv; v.op = op; v.imm = imm; v.rs = rs;
    v.hlt = hlt; v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_halted = e_halted; v.e_fault = e_fault; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    imem_ack = 0; imem_rdata = 0; instr_ready = 0; redirect_valid = 0;
    redirect_op = 0; redirect_imm = 0; redirect_rs = 0; halt = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic to_hold(input logic [31:0] word);
    do_reset();
    imem_ack = 1; imem_rdata = word;
    tick();
    tick();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential flow, redirects, aligned and misaligned jr.
    tbl.push_back(mk(1, 32'hAA,       1, 0, 2'd0, 26'h0,       32'h0,    0, 0, 32'h3000, 0, 32'h0,     0, 2'd0, 0));
    tbl.push_back(mk(1, 32'hA1,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h3000, 0, 32'h0,     0, 2'd0, 0));
    tbl.push_back(mk(1, 32'hBAD,      1, 0, 2'd0, 26'h0,       32'h0,    0, 0, 32'h3000, 1, 32'hA1,    0, 2'd0, 0));
    tbl.push_back(mk(1, 32'hA2,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h3004, 0, 32'hA1,    0, 2'd0, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 2'd0, 26'h3FFFFFF, 32'h0,    0, 0, 32'h3004, 1, 32'hA2,    0, 2'd0, 1));
    tbl.push_back(mk(1, 32'hA3,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h3008, 0, 32'hA2,    0, 2'd0, 2));
    tbl.push_back(mk(0, 32'h0,        1, 0, 2'd3, 26'h0,       32'hDEAD, 0, 0, 32'h3008, 1, 32'hA3,    0, 2'd0, 2));
    tbl.push_back(mk(1, 32'hA4,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h300C, 0, 32'hA3,    0, 2'd0, 3));
    tbl.push_back(mk(0, 32'h0,        1, 1, 2'd3, 26'h0,       32'h3004, 0, 0, 32'h300C, 1, 32'hA4,    0, 2'd0, 3));
    tbl.push_back(mk(1, 32'hA5,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h3004, 0, 32'hA4,    0, 2'd0, 4));
    tbl.push_back(mk(0, 32'h0,        1, 1, 2'd1, 26'hFFFF,    32'h0,    0, 0, 32'h3004, 1, 32'hA5,    0, 2'd0, 4));
    tbl.push_back(mk(1, 32'hA6,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h3004, 0, 32'hA5,    0, 2'd0, 5));
    tbl.push_back(mk(0, 32'h0,        1, 1, 2'd2, 26'hC00,     32'h0,    0, 0, 32'h3004, 1, 32'hA6,    0, 2'd0, 5));
    tbl.push_back(mk(1, 32'hA7,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h3000, 0, 32'hA6,    0, 2'd0, 6));
    tbl.push_back(mk(0, 32'h0,        1, 1, 2'd3, 26'h0,       32'h4000, 0, 0, 32'h3000, 1, 32'hA7,    0, 2'd0, 6));
    tbl.push_back(mk(1, 32'hA8,       1, 0, 2'd0, 26'h0,       32'h0,    0, 1, 32'h4000, 0, 32'hA7,    0, 2'd0, 7));
    tbl.push_back(mk(0, 32'h0,        1, 1, 2'd3, 26'h0,       32'h4002, 0, 0, 32'h4000, 1, 32'hA8,    0, 2'd0, 7));
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(1, 32'hF00D,   1, 0, 2'd0, 26'h0,       32'h0,    0, 0, 32'h4002, 0, 32'hA8,    1, 2'd1, 8));

    do_reset();
    chk("reset req", imem_req, 0);
    chk("reset valid", instr_valid, 0);
    chk("reset halted", halted, 0);
    chk("reset pc", pc, 32'h3000);
    chk("reset instr", instr, 0);
    chk("reset retire", retire_cnt, 0);
    chk("reset fault", fault, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; instr_ready = tbl[i].ready;
      redirect_valid = tbl[i].rv; redirect_op = tbl[i].op; redirect_imm = tbl[i].imm;
      redirect_rs = tbl[i].rs; halt = tbl[i].hlt;
      chk($sformatf("row%0d req", i), imem_req, tbl[i].e_req);
      chk($sformatf("row%0d addr", i), imem_addr, tbl[i].e_pc);
      chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d valid", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
      chk($sformatf("row%0d halted", i), halted, tbl[i].e_halted);
      chk($sformatf("row%0d fault", i), fault, tbl[i].e_fault);
      chk($sformatf("row%0d retire", i), retire_cnt, tbl[i].e_ret);
      tick();
    end

    // Wait states: 5-cycle delay, 15-cycle delay (last legal), then timeout.
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wait5 req%0d", i), imem_req, 1);
      tick();
    end
    imem_ack = 1; imem_rdata = 32'hC1;
    tick();
    imem_ack = 0;
    chk("wait5 valid", instr_valid, 1);
    chk("wait5 instr", instr, 32'hC1);
    chk("wait5 fault", fault, 0);
    instr_ready = 1;
    tick();
    instr_ready = 0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("wait15 req%0d", i), imem_req, 1);
      tick();
    end
    imem_ack = 1; imem_rdata = 32'hC2;
    tick();
    imem_ack = 0;
    chk("wait15 valid", instr_valid, 1);
    chk("wait15 instr", instr, 32'hC2);
    chk("wait15 halted", halted, 0);
    chk("wait15 fault", fault, 0);
    instr_ready = 1;
    tick();
    instr_ready = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("timeout req%0d", i), imem_req, 1);
      tick();
    end
    chk("timeout halted", halted, 1);
    chk("timeout fault", fault, 2);
    chk("timeout req", imem_req, 0);
    imem_ack = 1; imem_rdata = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("late ack instr%0d", i), instr, 32'hC2);
      chk($sformatf("late ack halted%0d", i), halted, 1);
      chk($sformatf("late ack valid%0d", i), instr_valid, 0);
    end

    // Stall with junk redirect/halt, then accept with halt.
    to_hold(32'hB1);
    redirect_valid = 1; redirect_op = 2'd2; redirect_imm = 26'h123; halt = 1;
    imem_ack = 1; imem_rdata = 32'hEEEE;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("stall valid%0d", i), instr_valid, 1);
      chk($sformatf("stall req%0d", i), imem_req, 0);
      chk($sformatf("stall pc%0d", i), pc, 32'h3000);
      chk($sformatf("stall instr%0d", i), instr, 32'hB1);
      tick();
    end
    clear_inputs();
    instr_ready = 1; halt = 1;
    tick();
    clear_inputs();
    chk("halt halted", halted, 1);
    chk("halt pc", pc, 32'h3004);
    chk("halt retire", retire_cnt, 1);
    chk("halt fault", fault, 0);
    chk("halt valid", instr_valid, 0);

    to_hold(32'hB2);
    instr_ready = 1; redirect_valid = 1; redirect_op = 2'd1; redirect_imm = 26'h0008; halt = 1;
    tick();
    clear_inputs();
    chk("halt+branch halted", halted, 1);
    chk("halt+branch pc", pc, 32'h3024);
    chk("halt+branch fault", fault, 0);

    to_hold(32'hB3);
    instr_ready = 1; redirect_valid = 1; redirect_op = 2'd3; redirect_rs = 32'h5001; halt = 1;
    tick();
    clear_inputs();
    chk("halt+jr halted", halted, 1);
    chk("halt+jr fault", fault, 1);
    chk("halt+jr pc", pc, 32'h5001);
    chk("halt+jr retire", retire_cnt, 1);

    // Reset during FETCH with an ack pending.
    do_reset();
    imem_ack = 1; imem_rdata = 32'hD1; instr_ready = 1;
    tick();
    tick();
    tick();
    chk("midrst pre pc", pc, 32'h3004);
    chk("midrst pre req", imem_req, 1);
    chk("midrst pre retire", retire_cnt, 1);
    imem_ack = 0;
    tick();
    rst = 1; imem_ack = 1; imem_rdata = 32'hD2;
    tick();
    rst = 0;
    chk("midrst pc", pc, 32'h3000);
    chk("midrst req", imem_req, 0);
    chk("midrst retire", retire_cnt, 0);
    chk("midrst fault", fault, 0);
    chk("midrst instr", instr, 0);
    chk("midrst valid", instr_valid, 0);
    tick();
    chk("midrst resume req", imem_req, 1);
    chk("midrst resume addr", imem_addr, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
